// File: rtl/mdu_pkg.sv
// Shared op-codes, FSM state encoding and op decode helpers for the multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL   = 3'd0;
  localparam logic [2:0] MDU_MULH  = 3'd1;
  localparam logic [2:0] MDU_MULHU = 3'd2;
  localparam logic [2:0] MDU_RSVD  = 3'd3;
  localparam logic [2:0] MDU_DIV   = 3'd4;
  localparam logic [2:0] MDU_MOD   = 3'd5;
  localparam logic [2:0] MDU_DIVU  = 3'd6;
  localparam logic [2:0] MDU_MODU  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV_RUN,
    ST_DIV_FIX,
    ST_DONE
  } mdu_state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed_div(input logic [2:0] op);
    return op[2] && !op[1];
  endfunction

endpackage

// File: rtl/div_iter.sv
// Unsigned iterative restoring divider: one quotient bit per clock, W steps after start.
module div_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         kill,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  rem_reg;
  logic [W-1:0]  quo_reg;
  logic [W-1:0]  dsr_reg;
  logic [CW-1:0] cnt_reg;
  logic          run_reg;
  logic          done_reg;

  // Partial remainder shifted left with the next dividend bit, then trial subtract.
  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted = {rem_reg, quo_reg[W-1]};
  assign diff    = shifted - {1'b0, dsr_reg};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      dsr_reg  <= '0;
      cnt_reg  <= '0;
      run_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else if (kill) begin
      run_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else if (start) begin
      rem_reg  <= '0;
      quo_reg  <= dividend;
      dsr_reg  <= divisor;
      cnt_reg  <= CW'(W - 1);
      run_reg  <= 1'b1;
      done_reg <= 1'b0;
    end else if (run_reg) begin
      if (diff[W]) begin
        rem_reg <= shifted[W-1:0];
        quo_reg <= {quo_reg[W-2:0], 1'b0};
      end else begin
        rem_reg <= diff[W-1:0];
        quo_reg <= {quo_reg[W-2:0], 1'b1};
      end
      if (cnt_reg == '0) begin
        run_reg  <= 1'b0;
        done_reg <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  assign quotient  = quo_reg;
  assign remainder = rem_reg;
  assign done      = done_reg;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit for EX: one op in flight, valid/ready in and out, flush kills.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int W       = 32,
  parameter int MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [W-1:0] in_src1,
  input  logic [W-1:0] in_src2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         busy
);

  localparam int LCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  mdu_state_e      state_reg;
  logic [2:0]      op_reg;
  logic [W-1:0]    src1_reg;
  logic [W-1:0]    src2_reg;
  logic [LCW-1:0]  lat_reg;
  logic            qneg_reg;
  logic            rneg_reg;
  logic            dz_reg;
  logic [2*W-1:0]  prod_reg;
  logic [W-1:0]    out_result_reg;

  logic            accept;
  logic            sdiv;
  logic            neg1;
  logic            neg2;
  logic [W-1:0]    abs1;
  logic [W-1:0]    abs2;

  assign accept = in_valid && (state_reg == ST_IDLE) && !flush;
  assign sdiv   = is_signed_div(in_op);
  assign neg1   = sdiv && in_src1[W-1];
  assign neg2   = sdiv && in_src2[W-1];
  assign abs1   = neg1 ? -in_src1 : in_src1;
  assign abs2   = neg2 ? -in_src2 : in_src2;

  // W+1-bit operands so one signed multiplier serves both MULH and the unsigned forms.
  logic signed [W:0]     mul_a;
  logic signed [W:0]     mul_b;
  logic signed [2*W-1:0] prod_comb;
  logic [2*W-1:0]        prod_sel;
  logic [W-1:0]          mul_res;

  assign mul_a     = {(op_reg == MDU_MULH) && src1_reg[W-1], src1_reg};
  assign mul_b     = {(op_reg == MDU_MULH) && src2_reg[W-1], src2_reg};
  assign prod_comb = mul_a * mul_b;
  assign prod_sel  = (MUL_LAT > 1) ? prod_reg : prod_comb;

  always_comb begin
    mul_res = '0;
    case (op_reg)
      MDU_MUL:             mul_res = prod_sel[W-1:0];
      MDU_MULH, MDU_MULHU: mul_res = prod_sel[2*W-1:W];
      default:             mul_res = '0;
    endcase
  end

  logic [W-1:0] core_q;
  logic [W-1:0] core_r;
  logic         core_done;

  div_iter #(.W(W)) u_div_iter (
    .clk       (clk),
    .resetn    (resetn),
    .start     (accept && is_div(in_op)),
    .kill      (flush),
    .dividend  (abs1),
    .divisor   (abs2),
    .quotient  (core_q),
    .remainder (core_r),
    .done      (core_done)
  );

  logic [W-1:0] fix_q;
  logic [W-1:0] fix_r;
  logic [W-1:0] div_res;

  assign fix_q   = qneg_reg ? -core_q : core_q;
  assign fix_r   = rneg_reg ? -core_r : core_r;
  // Divide by zero skips the sign fixup: all-ones quotient, original dividend as remainder.
  assign div_res = dz_reg ? (op_reg[0] ? src1_reg : '1)
                          : (op_reg[0] ? fix_r : fix_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      op_reg         <= '0;
      src1_reg       <= '0;
      src2_reg       <= '0;
      lat_reg        <= '0;
      qneg_reg       <= 1'b0;
      rneg_reg       <= 1'b0;
      dz_reg         <= 1'b0;
      prod_reg       <= '0;
      out_result_reg <= '0;
    end else if (flush) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            op_reg    <= in_op;
            src1_reg  <= in_src1;
            src2_reg  <= in_src2;
            lat_reg   <= LCW'(MUL_LAT - 1);
            qneg_reg  <= neg1 ^ neg2;
            rneg_reg  <= neg1;
            dz_reg    <= (in_src2 == '0);
            state_reg <= is_div(in_op) ? ST_DIV_RUN : ST_MUL;
          end
        end
        ST_MUL: begin
          prod_reg <= prod_comb;
          if (lat_reg == '0) begin
            out_result_reg <= mul_res;
            state_reg      <= ST_DONE;
          end else begin
            lat_reg <= lat_reg - 1'b1;
          end
        end
        ST_DIV_RUN: begin
          if (core_done) state_reg <= ST_DIV_FIX;
        end
        ST_DIV_FIX: begin
          out_result_reg <= div_res;
          state_reg      <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_reg == ST_IDLE);
  assign out_valid  = (state_reg == ST_DONE);
  assign busy       = (state_reg != ST_IDLE);
  assign out_result = out_result_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and randomized checks of mul_div_unit (W=32, MUL_LAT=2) against an arithmetic reference.
module tb_mul_div_unit;

  localparam int W       = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = W + 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [W-1:0]  in_src1 = '0;
  logic [W-1:0]  in_src2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic          busy;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.W(W), .MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as the ISA defines them.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          ps;
    longint unsigned pu;
    logic [63:0]     p64;
    logic [31:0]     r;
    ps = longint'($signed(a)) * longint'($signed(b));
    pu = {32'd0, a} * {32'd0, b};
    r  = '0;
    case (op)
      3'd0: begin p64 = ps; r = p64[31:0]; end
      3'd1: begin p64 = ps; r = p64[63:32]; end
      3'd2: begin p64 = pu; r = p64[63:32]; end
      3'd3: r = '0;
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 :
                32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? a :
                (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 :
                32'($signed(a) % $signed(b));
      3'd6: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Issue one op; hold > 0 keeps out_ready low for that many cycles once the result appears.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    int          n;
    int          exp_lat;
    logic [31:0] exp_res;
    logic [31:0] held;
    exp_res = ref_model(op, a, b);
    exp_lat = op[2] ? DIV_LAT : MUL_LAT;
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = op;
    in_src1   = a;
    in_src2   = b;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'(exp_lat));
    check({tag, ".result"}, out_result, exp_res);
    $display("op=%0d a=0x%08h b=0x%08h result=0x%08h expected=0x%08h latency=%0d",
             op, a, b, out_result, exp_res, n);
    held = out_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_result"}, out_result, held);
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
    end
    if (hold > 0) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, ".valid_after"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [5];
    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_result", out_result, 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Multiply directed cases
    do_op("mul", 3'd0, 32'h0000_0003, 32'hFFFF_FFFE, 0);
    do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    do_op("mulhu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("rsvd", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    // Divide directed cases
    do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("mod", 3'd5, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("divu", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("modu", 3'd7, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("mod_ovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("div_zero", 3'd4, 32'd5, 32'd0, 0);
    do_op("mod_zero", 3'd5, 32'hFFFF_FFF9, 32'd0, 0);

    // Backpressure then back-to-back multiply
    do_op("bp", 3'd6, 32'd1000, 32'd3, 5);
    do_op("b2b", 3'd0, 32'd12345, 32'd678, 0);

    // Flush on edge 10 of a divide
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 3'd4;
    in_src1  = 32'd1000;
    in_src2  = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush.in_ready", 32'(in_ready), 32'd1);
    check("flush.out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush.never_valid", 32'(seen), 32'd0);
    $display("flush of div at edge 10: out_valid cycles seen afterwards=%0d", seen);
    do_op("post_flush_mul", 3'd0, 32'd7, 32'd6, 0);

    // Async reset in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 3'd6;
    in_src1  = 32'd999;
    in_src2  = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("areset.in_ready", 32'(in_ready), 32'd1);
    check("areset.out_valid", 32'(out_valid), 32'd0);
    check("areset.out_result", out_result, 32'd0);
    check("areset.busy", 32'(busy), 32'd0);
    $display("async reset mid-div: in_ready=%0d out_valid=%0d out_result=0x%08h busy=%0d",
             in_ready, out_valid, out_result, busy);
    @(negedge clk);
    resetn = 1'b1;
    do_op("post_reset_divu", 3'd6, 32'd100, 32'd7, 0);

    // Randomized ops against the reference
    for (int k = 0; k < 30; k++) begin
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 3'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      do_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
